// File: rtl/pin_pkg.sv
// pin_collision shared types and pin-triangle geometry.
// Pins are row-major: row r holds r+1 pins, head pin is index 0.
package pin_pkg;

    localparam int NUM_PINS = 10;

    typedef logic [10:0] xpos_t;
    typedef logic [9:0]  ypos_t;
    typedef logic [NUM_PINS-1:0] mask_t;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        REPORT
    } state_t;

    function automatic int pin_row(input logic [3:0] idx);
        if (idx >= 4'd6)      return 3;
        else if (idx >= 4'd3) return 2;
        else if (idx >= 4'd1) return 1;
        else                  return 0;
    endfunction

    function automatic xpos_t pin_x(input logic [3:0] idx,
                                    input int base,
                                    input int spacing);
        return xpos_t'(base + pin_row(idx) * spacing);
    endfunction

    function automatic ypos_t pin_y(input logic [3:0] idx,
                                    input int base,
                                    input int spacing);
        int r;
        int k;
        r = pin_row(idx);
        k = int'(idx) - (r * (r + 1)) / 2;
        return ypos_t'(base + ((2 * k - r) * spacing) / 2);
    endfunction

    function automatic logic [3:0] pin_count(input mask_t m);
        logic [3:0] c;
        c = '0;
        for (int i = 0; i < NUM_PINS; i++) c = c + 4'(m[i]);
        return c;
    endfunction

endpackage

// File: rtl/pin_collision_if.sv
// Bundle between ball kinematics, pin_collision and frame/score logic.
// master drives ball state, slave reports knocked pins and score.
interface pin_collision_if;
    logic [10:0] ball_x;
    logic [9:0]  ball_y;
    logic        check_collision;
    logic        ball_done;
    logic        clear_in;
    logic [9:0]  pins_down;
    logic        hit_valid;
    logic [3:0]  hit_index;
    logic [3:0]  score;
    logic        score_valid;
    logic        busy;

    modport master (
        output ball_x, ball_y, check_collision, ball_done, clear_in,
        input  pins_down, hit_valid, hit_index, score, score_valid, busy
    );

    modport slave (
        input  ball_x, ball_y, check_collision, ball_done, clear_in,
        output pins_down, hit_valid, hit_index, score, score_valid, busy
    );
endinterface

// File: rtl/dist_sq_cmp.sv
// Squared-distance test of the ball against one pin centre.
// Hit is inclusive of the touching boundary.
module dist_sq_cmp
    import pin_pkg::*;
#(
    parameter int THRESH = 196
) (
    input  xpos_t ball_x,
    input  ypos_t ball_y,
    input  xpos_t pin_x,
    input  ypos_t pin_y,
    output logic  hit
);

    logic signed [11:0] dx;
    logic signed [10:0] dy;
    logic signed [23:0] dx_w;
    logic signed [23:0] dy_w;
    logic        [23:0] d2;

    assign dx   = signed'({1'b0, ball_x} - {1'b0, pin_x});
    assign dy   = signed'({1'b0, ball_y} - {1'b0, pin_y});
    assign dx_w = 24'(dx);
    assign dy_w = 24'(dy);
    assign d2   = unsigned'(dx_w * dx_w) + unsigned'(dy_w * dy_w);
    assign hit  = (d2 <= 24'(THRESH));

endmodule

// File: rtl/pin_collision.sv
// Scans the 10-pin triangle, one pin per cycle, for each new ball position.
// Keeps a sticky knocked mask and reports a pin count after each roll.
module pin_collision
    import pin_pkg::*;
#(
    parameter int BALL_R      = 8,
    parameter int PIN_R       = 6,
    parameter int PIN_BASE_X  = 700,
    parameter int PIN_BASE_Y  = 384,
    parameter int PIN_SPACING = 40
) (
    input  logic            clk_in,
    input  logic            rst_in,
    pin_collision_if.slave  bus
);

    localparam int THRESH = (BALL_R + PIN_R) * (BALL_R + PIN_R);

    state_t     state;
    logic [3:0] idx;
    logic       done_pend;
    logic       last_valid;
    xpos_t      last_x;
    ypos_t      last_y;
    mask_t      pins_q;
    mask_t      mask_next;
    xpos_t      cur_px;
    ypos_t      cur_py;
    logic       hit;
    logic       newly;
    logic       start;
    logic       hit_valid_q;
    logic [3:0] hit_index_q;
    logic [3:0] score_q;
    logic       score_valid_q;
    logic       busy_q;

    assign cur_px = pin_x(idx, PIN_BASE_X, PIN_SPACING);
    assign cur_py = pin_y(idx, PIN_BASE_Y, PIN_SPACING);

    // Scan uses the latched position so mid-scan updates are ignored
    dist_sq_cmp #(.THRESH(THRESH)) u_cmp (
        .ball_x (last_x),
        .ball_y (last_y),
        .pin_x  (cur_px),
        .pin_y  (cur_py),
        .hit    (hit)
    );

    assign start = bus.check_collision &&
                   (!last_valid || bus.ball_x != last_x ||
                    bus.ball_y != last_y);

    always_comb begin
        newly     = (state == SCAN) && hit && !pins_q[idx];
        mask_next = pins_q;
        if (newly) mask_next[idx] = 1'b1;
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state         <= IDLE;
            idx           <= '0;
            done_pend     <= 1'b0;
            last_valid    <= 1'b0;
            last_x        <= '0;
            last_y        <= '0;
            pins_q        <= '0;
            hit_valid_q   <= 1'b0;
            hit_index_q   <= '0;
            score_q       <= '0;
            score_valid_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            hit_valid_q   <= 1'b0;
            score_valid_q <= 1'b0;
            if (bus.clear_in) begin
                state      <= IDLE;
                idx        <= '0;
                done_pend  <= 1'b0;
                last_valid <= 1'b0;
                pins_q     <= '0;
                busy_q     <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (bus.ball_done) begin
                            state         <= REPORT;
                            score_q       <= pin_count(pins_q);
                            score_valid_q <= 1'b1;
                            done_pend     <= 1'b0;
                            busy_q        <= 1'b1;
                        end else if (start) begin
                            state      <= SCAN;
                            idx        <= '0;
                            last_x     <= bus.ball_x;
                            last_y     <= bus.ball_y;
                            last_valid <= 1'b1;
                            busy_q     <= 1'b1;
                        end
                    end
                    SCAN: begin
                        pins_q <= mask_next;
                        if (newly) begin
                            hit_valid_q <= 1'b1;
                            hit_index_q <= idx;
                        end
                        if (bus.ball_done) done_pend <= 1'b1;
                        if (idx == 4'(NUM_PINS - 1)) begin
                            idx <= '0;
                            if (done_pend || bus.ball_done) begin
                                // Count includes a hit on the final pin
                                state         <= REPORT;
                                score_q       <= pin_count(mask_next);
                                score_valid_q <= 1'b1;
                                done_pend     <= 1'b0;
                            end else begin
                                state  <= IDLE;
                                busy_q <= 1'b0;
                            end
                        end else begin
                            idx <= idx + 4'd1;
                        end
                    end
                    REPORT: begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end
                    default: begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.pins_down   = pins_q;
    assign bus.hit_valid   = hit_valid_q;
    assign bus.hit_index   = hit_index_q;
    assign bus.score       = score_q;
    assign bus.score_valid = score_valid_q;
    assign bus.busy        = busy_q;

endmodule

// File: doc/pin_collision.md
# pin_collision

Downstream consumer of the ball kinematics stage: watches `ball_x`/`ball_y` while `check_collision` is high and tests each new position against a fixed 10‑pin triangle. It accumulates a sticky knocked‑pin mask and emits per‑hit pulses. When the ball finishes, it reports a one‑cycle pin count to the frame/score logic.

## Interface
- `BALL_R`, 8: ball radius in pixels
- `PIN_R`, 6: pin radius in pixels
- `PIN_BASE_X`, 700: head‑pin x (pixels)
- `PIN_BASE_Y`, 384: head‑pin y (pixels)
- `PIN_SPACING`, 40: row pitch in x and pin pitch in y (must be even)
- `clk_in`  in  1  system clock
- `rst_in`  in  1  reset; one clock; reset is asynchronous and active-high
- `ball_x`  in  11  ball x position (unsigned)
- `ball_y`  in  10  ball y position (unsigned)
- `check_collision`  in  1  level; ball is in the pin region
- `ball_done`  in  1  single‑cycle pulse; roll finished
- `clear_in`  in  1  single‑cycle pulse; new frame, stand all pins
- `pins_down`  out  10  sticky knocked mask; bit i = pin i
- `hit_valid`  out  1  one‑cycle pulse, pin newly knocked
- `hit_index`  out  4  index of that pin; valid with `hit_valid`
- `score`  out  4  popcount of `pins_down`; valid with `score_valid`
- `score_valid`  out  1  one‑cycle pulse after `ball_done`
- `busy`  out  1  high in SCAN or REPORT

## Operation
- Pin geometry: row r = 0..3 holds r+1 pins, row‑major index 0..9.
  - Pin (r,k): x = PIN_BASE_X + r·PIN_SPACING; y = PIN_BASE_Y + (2k−r)·PIN_SPACING/2.
- FSM states IDLE, SCAN, REPORT.
- IDLE → SCAN when `check_collision`=1 and (`ball_x`,`ball_y`) ≠ last scanned position, or when no position has been scanned since reset/clear.
  - On entry: latch the position into `last_x`/`last_y`; pin counter `idx`=0.
- SCAN evaluates pin `idx` once per cycle, then increments `idx`. After `idx`=9, go to IDLE, or to REPORT if a `ball_done` is pending.
- Hit test, per pin:
  - dx = ball_x − pin_x, 12‑bit signed; dy = ball_y − pin_y, 11‑bit signed.
  - d2 = dx² + dy², 24‑bit unsigned.
  - Hit iff d2 ≤ (BALL_R+PIN_R)², i.e. boundary inclusive.
- Hit on a pin whose `pins_down` bit is 0: set the bit, pulse `hit_valid`, drive `hit_index`=idx. Already‑down pins never re‑pulse.
- `ball_done`:
  - In IDLE: go to REPORT.
  - In SCAN: set `done_pend`; REPORT follows scan completion.
- REPORT lasts one cycle: `score_valid`=1, `score`=popcount(`pins_down`), clear `done_pend`, go to IDLE. `pins_down` is retained.
- `clear_in` (any state):
  - Next state IDLE; `pins_down`=0; `done_pend`=0.
  - Invalidate last position, so the next `check_collision` always scans.
  - No `hit_valid` or `score_valid` is emitted that cycle.
- Priority: `rst_in` > `clear_in` > `ball_done` > scan start.
  - `clear_in` and `ball_done` together: clear wins, no report.
- `check_collision` dropping mid‑scan does not abort the scan.

## Timing
- Reset values: `pins_down`=0, `hit_valid`=0, `hit_index`=0, `score`=0, `score_valid`=0, `busy`=0. FSM=IDLE, `idx`=0, `done_pend`=0, last position invalid.
- Start condition sampled at edge t → `busy`=1 from t+1.
- Pin i is evaluated in cycle t+1+i. Its `pins_down` bit and `hit_valid`/`hit_index` are registered at edge t+2+i.
- Scan length 10 cycles; `busy` drops at t+11 if no report is pending.
- `ball_done` sampled in IDLE at edge t → `score_valid` high in cycle t+1.
- `ball_done` during SCAN → `score_valid` in the cycle immediately after the last pin evaluation. Latency is at most 11 cycles.
- New positions arriving mid‑scan are ignored. The next scan uses the position present when IDLE is re‑entered. The kinematics update period is millions of cycles, so no position is lost.
- Asynchronous reset mid‑scan: all outputs go to reset values immediately, with no partial pulses.

## Structure
- Package `pin_pkg`:
  - `NUM_PINS`=10.
  - FSM state enum.
  - Functions `pin_x(idx)` and `pin_y(idx)`, parameterised by base and spacing.
- One sub‑module `dist_sq_cmp`: combinational dx/dy/d2 and threshold compare for one pin. Instantiated once and time‑multiplexed by `idx`.

## Test plan
With default parameters: pin0 (700,384); pin4 (780,384); threshold 196.
- Reset: assert `rst_in` asynchronously mid‑cycle → all outputs 0 at once; `busy`=0.
- Ball (700,384), `check_collision`=1 → after 11 cycles `pins_down`=10'h001, exactly one `hit_valid` with `hit_index`=0.
- Boundary:
  - Ball (714,384): d2=196 → pin0 hit.
  - Fresh frame, ball (715,384): d2=225 → no hit, `pins_down`=0.
- Ball (700,384), then (780,384), then `ball_done` → `pins_down`=10'h011, two `hit_valid` pulses (0, 4), then one `score_valid` with `score`=2. Repeating (700,384) gives no new pulse.
- `ball_done` 3 cycles into a scan → `score_valid` exactly one cycle after the scan ends; only one pulse.
- `clear_in` 5 cycles into a scan that would hit pin 9 → `pins_down`=0, `busy`=0 next cycle, no `hit_valid`. The same position rescans on the next `check_collision`.
